// File: rtl/intr_host_seq_if.sv
// rtl/intr_host_seq_if.sv - pin bundle between host sequencer and interrupt controller
interface intr_host_seq_if;
    logic       intr_out;
    logic       intr_in;
    logic       bus_oe;
    logic [7:0] bus_in;
    logic [7:0] bus_out;

    // Host side: drives the ack line and its half of the shared bus
    modport master (
        input  intr_out,
        input  bus_oe,
        input  bus_in,
        output intr_in,
        output bus_out
    );

    // Controller side
    modport slave (
        output intr_out,
        output bus_oe,
        output bus_in,
        input  intr_in,
        input  bus_out
    );
endinterface

// File: rtl/intr_host_seq.sv
// rtl/intr_host_seq.sv - hardware handshake sequencer servicing the interrupt controller
module intr_host_seq #(
    parameter int ACK_DLY  = 6,
    parameter int ADDR_DLY = 6,
    parameter int GAP_DLY  = 10,
    parameter int VEC_TMO  = 15
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   cfg_start,
    input  logic                   cfg_mode,
    input  logic [23:0]            cfg_prio,
    intr_host_seq_if.master        ic,
    output logic [7:0]             clr_rq,
    output logic                   svc_valid,
    output logic [2:0]             svc_id,
    input  logic                   svc_done,
    output logic                   busy,
    output logic                   err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_WAIT_INT,
        S_ACK_DLY,
        S_ACK1,
        S_VEC,
        S_ADDR_DLY,
        S_ACK2,
        S_SVC,
        S_EOI,
        S_GAP
    } state_t;

    localparam logic [7:0] ACK_LD  = 8'(ACK_DLY);
    localparam logic [7:0] ADDR_LD = 8'(ADDR_DLY);
    localparam logic [7:0] GAP_LD  = 8'(GAP_DLY);
    localparam logic [7:0] TMO_LD  = 8'(VEC_TMO);

    state_t      state;
    logic [7:0]  cnt;
    logic        mode_r;
    logic [23:0] prio_sh;
    logic [4:0]  vec_prefix;
    logic [4:0]  eoi_prefix;

    // Vector prefix and EOI command differ between polling and priority modes
    always_comb begin
        vec_prefix = mode_r ? 5'b10011 : 5'b01011;
        eoi_prefix = mode_r ? 5'b01100 : 5'b10100;
    end

    // busy is a pure decode of the state register
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Main sequencer: all outputs registered; counters run from load value down to 1
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            mode_r     <= 1'b0;
            prio_sh    <= 24'd0;
            ic.intr_in <= 1'b1;
            ic.bus_out <= 8'h00;
            clr_rq     <= 8'h00;
            svc_valid  <= 1'b0;
            svc_id     <= 3'd0;
            err        <= 1'b0;
        end else begin
            err    <= 1'b0;
            clr_rq <= 8'h00;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        mode_r <= cfg_mode;
                        state  <= S_CFG;
                        if (cfg_mode) begin
                            // First priority word goes out now; cnt holds the words still to send
                            ic.bus_out <= {cfg_prio[23:18], 2'b10};
                            prio_sh    <= {cfg_prio[17:0], 6'b0};
                            cnt        <= 8'd3;
                        end else begin
                            ic.bus_out <= 8'h01;
                            prio_sh    <= cfg_prio;
                            cnt        <= 8'd0;
                        end
                    end
                end
                S_CFG: begin
                    if (cnt == 8'd0) begin
                        ic.bus_out <= 8'h00;
                        state      <= S_WAIT_INT;
                    end else begin
                        ic.bus_out <= {prio_sh[23:18], 2'b10};
                        prio_sh    <= {prio_sh[17:0], 6'b0};
                        cnt        <= cnt - 8'd1;
                    end
                end
                S_WAIT_INT: begin
                    if (ic.intr_out) begin
                        cnt   <= ACK_LD;
                        state <= S_ACK_DLY;
                    end
                end
                S_ACK_DLY: begin
                    // Hold off the first ack while the controller still owns the bus
                    if (cnt == 8'd1) begin
                        if (!ic.bus_oe) begin
                            ic.intr_in <= 1'b0;
                            state      <= S_ACK1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_ACK1: begin
                    ic.intr_in <= 1'b1;
                    cnt        <= TMO_LD;
                    state      <= S_VEC;
                end
                S_VEC: begin
                    if (ic.bus_oe) begin
                        if (ic.bus_in[7:3] == vec_prefix) begin
                            svc_id <= ic.bus_in[2:0];
                            cnt    <= ADDR_LD;
                            state  <= S_ADDR_DLY;
                        end else begin
                            // Controller is not in the mode we programmed: reconfigure from scratch
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else if (cnt == 8'd1) begin
                        err   <= 1'b1;
                        state <= S_WAIT_INT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_ADDR_DLY: begin
                    if (cnt == 8'd1) begin
                        ic.intr_in <= 1'b0;
                        state      <= S_ACK2;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_ACK2: begin
                    ic.intr_in <= 1'b1;
                    svc_valid  <= 1'b1;
                    clr_rq     <= 8'd1 << svc_id;
                    state      <= S_SVC;
                end
                S_SVC: begin
                    if (svc_done) begin
                        svc_valid  <= 1'b0;
                        ic.bus_out <= {eoi_prefix, svc_id};
                        ic.intr_in <= 1'b0;
                        state      <= S_EOI;
                    end
                end
                S_EOI: begin
                    ic.bus_out <= 8'h00;
                    ic.intr_in <= 1'b1;
                    cnt        <= GAP_LD;
                    state      <= S_GAP;
                end
                S_GAP: begin
                    if (cnt == 8'd1) begin
                        state <= S_WAIT_INT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_host_seq.sv
// tb/tb_intr_host_seq.sv - directed self-checking bench for intr_host_seq
module tb_intr_host_seq;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cfg_start;
    logic        cfg_mode;
    logic [23:0] cfg_prio;
    logic [7:0]  clr_rq;
    logic        svc_valid;
    logic [2:0]  svc_id;
    logic        svc_done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    intr_host_seq_if ic ();

    intr_host_seq #(
        .ACK_DLY  (6),
        .ADDR_DLY (6),
        .GAP_DLY  (10),
        .VEC_TMO  (15)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .cfg_start (cfg_start),
        .cfg_mode  (cfg_mode),
        .cfg_prio  (cfg_prio),
        .ic        (ic.master),
        .clr_rq    (clr_rq),
        .svc_valid (svc_valid),
        .svc_id    (svc_id),
        .svc_done  (svc_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count negedges until intr_in is seen low (bounded)
    task automatic wait_ack(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ic.intr_in !== 1'b0 && n < max);
    endtask

    // Count negedges until err is seen high (bounded)
    task automatic wait_err(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (err !== 1'b1 && n < max);
    endtask

    int n;
    logic bad_seen;

    initial begin
        rst_in      = 1'b0;
        cfg_start   = 1'b0;
        cfg_mode    = 1'b0;
        cfg_prio    = 24'd0;
        svc_done    = 1'b0;
        ic.intr_out = 1'b0;
        ic.bus_oe   = 1'b0;
        ic.bus_in   = 8'h00;

        // Reset state
        tick();
        chk("rst_intr_in", ic.intr_in, 1);
        chk("rst_bus_out", ic.bus_out, 8'h00);
        chk("rst_clr_rq", clr_rq, 8'h00);
        chk("rst_svc", {svc_valid, svc_id}, 4'h0);
        chk("rst_busy_err", {busy, err}, 2'b00);
        rst_in = 1'b1;
        tick();

        // Polling configuration: one 8'h01 cycle
        cfg_mode  = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("poll_cfg_word", ic.bus_out, 8'h01);
        chk("poll_busy", busy, 1);
        tick();
        chk("poll_cfg_end", ic.bus_out, 8'h00);

        // intr_out first sampled at the next rising edge; ack lands 6 edges later (7th negedge)
        ic.intr_out = 1'b1;
        wait_ack(40, n);
        chk("poll_ack1_dly", n, 7);
        tick();
        chk("poll_ack1_width", ic.intr_in, 1);
        ic.bus_oe = 1'b1;
        ic.bus_in = 8'h59;
        wait_ack(40, n);
        chk("poll_ack2_dly", n, 7);
        ic.bus_oe = 1'b0;
        ic.bus_in = 8'h00;
        tick();
        chk("poll_svc_valid", svc_valid, 1);
        chk("poll_svc_id", svc_id, 3'd1);
        chk("poll_clr_rq", clr_rq, 8'h02);
        tick();
        chk("poll_clr_rq_pulse", clr_rq, 8'h00);
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        chk("poll_eoi_word", ic.bus_out, 8'hA1);
        chk("poll_eoi_ack", {ic.intr_in, svc_valid}, 2'b00);

        // Back-to-back: intr_out still high; next ack at EOI-end edge + GAP + ACK + 1 edges
        wait_ack(60, n);
        chk("b2b_ack1_dly", n, 18);
        chk("b2b_bus_out", ic.bus_out, 8'h00);

        // Timeout: bus_oe never asserts; err 15 cycles after VEC entry
        wait_err(60, n);
        chk("tmo_err_dly", n, 16);
        tick();
        chk("tmo_err_pulse", {err, busy}, 2'b01);
        // intr_out still high, so it re-arms immediately and is serviced normally
        wait_ack(40, n);
        chk("tmo_rearm_ack1", n, 6);
        ic.intr_out = 1'b0;
        tick();
        ic.bus_oe = 1'b1;
        ic.bus_in = 8'h59;
        wait_ack(40, n);
        ic.bus_oe = 1'b0;
        ic.bus_in = 8'h00;
        tick();
        chk("tmo_next_clr_rq", clr_rq, 8'h02);

        // cfg_start while busy is ignored
        cfg_mode  = 1'b1;
        cfg_prio  = 24'hFFFFFF;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("busy_cfg_ignored", {ic.bus_out, svc_valid}, {8'h00, 1'b1});

        // Reset mid-SVC takes effect without waiting for a clock edge
        #2;
        rst_in = 1'b0;
        #1;
        chk("rst_svc_valid", svc_valid, 0);
        chk("rst_mid_pins", {ic.intr_in, ic.bus_out}, {1'b1, 8'h00});
        chk("rst_mid_busy", busy, 0);
        tick();
        rst_in = 1'b1;
        tick();

        // Priority configuration: order 5,3,7,0,4,2,6,1
        cfg_mode  = 1'b1;
        cfg_prio  = 24'hAF88B1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("prio_w0", ic.bus_out, 8'hAE);
        tick();
        chk("prio_w1", ic.bus_out, 8'hE2);
        tick();
        chk("prio_w2", ic.bus_out, 8'h8A);
        tick();
        chk("prio_w3", ic.bus_out, 8'hC6);
        tick();
        chk("prio_cfg_end", ic.bus_out, 8'h00);

        ic.intr_out = 1'b1;
        wait_ack(40, n);
        chk("prio_ack1_dly", n, 7);
        ic.intr_out = 1'b0;
        tick();
        ic.bus_oe = 1'b1;
        ic.bus_in = 8'h9D;
        wait_ack(40, n);
        ic.bus_oe = 1'b0;
        ic.bus_in = 8'h00;
        tick();
        chk("prio_svc_id", svc_id, 3'd5);
        chk("prio_clr_rq", clr_rq, 8'h20);
        // svc_done in the very first SVC cycle is accepted
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        chk("prio_eoi_word", ic.bus_out, 8'h65);
        chk("prio_eoi_ack", ic.intr_in, 0);
        repeat (12) tick();

        // Bad vector in priority mode
        ic.intr_out = 1'b1;
        wait_ack(40, n);
        chk("bad_ack1_dly", n, 7);
        ic.intr_out = 1'b0;
        tick();
        ic.bus_oe = 1'b1;
        ic.bus_in = 8'h5D;
        tick();
        chk("bad_err", {err, busy}, 2'b10);
        chk("bad_clr_rq", clr_rq, 8'h00);
        ic.bus_oe = 1'b0;
        ic.bus_in = 8'h00;
        tick();
        chk("bad_err_pulse", err, 0);
        bad_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ic.intr_in !== 1'b1 || clr_rq !== 8'h00 || svc_valid !== 1'b0 ||
                ic.bus_out !== 8'h00 || busy !== 1'b0)
                bad_seen = 1'b1;
        end
        chk("bad_quiet_after", bad_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_host_seq.md
Name: intr_host_seq

Overview:
- Host-side sequencer that configures and services the interrupt controller block (intr_out/intr_in/intr_bus/bus_oe pins).
- Performs the processor's handshake in hardware: the mode/priority programming writes, the two active-low acks, vector capture, request clearing, ISR dispatch and end-of-interrupt (EOI) write.
- Sits between the interrupt controller and the ISR engine. Drives the controller's intr_in and the host half of intr_bus.

Parameters:
ACK_DLY, 6, clock cycles from intr_out seen high to first ack pulse (min 1)
ADDR_DLY, 6, clock cycles between vector capture and second ack pulse (min 1)
GAP_DLY, 10, idle cycles after EOI before re-arming on intr_out (min 1)
VEC_TMO, 15, max cycles to wait for bus_oe after first ack

Ports:
clk_in  in  1  clock, all logic on rising edge
rst_in  in  1  asynchronous, active-low reset
cfg_start  in  1  1-cycle pulse: program controller and enter service loop
cfg_mode  in  1  0 = polling, 1 = priority
cfg_prio  in  24  priority order, highest first; [23:21] = rank0 id ... [2:0] = rank7 id
ic_intr_out  in  1  interrupt from controller
ic_intr_in  out  1  active-low ack to controller
ic_bus_oe  in  1  1 = controller drives bus
ic_bus_in  in  8  bus value when controller drives
ic_bus_out  out  8  host bus value; only meaningful while ic_bus_oe = 0
clr_rq  out  8  1-cycle one-hot pulse clearing the serviced request source
svc_valid  out  1  ISR active for svc_id
svc_id  out  3  id being serviced
svc_done  in  1  ISR complete (sampled only while svc_valid)
busy  out  1  high in every state except IDLE
err  out  1  1-cycle pulse on vector error/timeout

Behaviour:
- Reset values (async, rst_in low): state IDLE, ic_intr_in = 1, ic_bus_out = 8'h00, clr_rq = 0, svc_valid = 0, svc_id = 0, busy = 0, err = 0, all counters 0.
- Reset mid-operation aborts immediately to IDLE. No EOI is issued.
- States: IDLE, CFG, WAIT_INT, ACK_DLY, ACK1, VEC, ADDR_DLY, ACK2, SVC, EOI, GAP.
- IDLE: on cfg_start, latch cfg_mode and cfg_prio, then go to CFG. cfg_start outside IDLE is ignored.
- CFG, polling mode: drive ic_bus_out = 8'h01 for 1 cycle, then go to WAIT_INT.
- CFG, priority mode: 4 consecutive cycles with ic_bus_out = {rank2k id, rank2k+1 id, 2'b10} for k = 0..3. Example: order 5,3,7,0,4,2,6,1 gives 8'hAE, 8'hE2, 8'h8A, 8'hC6. Then go to WAIT_INT.
- ic_bus_out = 8'h00 in all states except the CFG and EOI cycles.
- WAIT_INT: when ic_intr_out = 1, load counter and go to ACK_DLY.
- ACK_DLY: count ACK_DLY cycles, then ACK1.
- ACK1: ic_intr_in = 0 for exactly 1 cycle, then VEC.
- VEC: wait for ic_bus_oe = 1 and capture ic_bus_in the same cycle.
  - Expected prefix [7:3]: 5'b01011 in polling mode, 5'b10011 in priority mode.
  - Match: svc_id <= bus[2:0], go to ADDR_DLY.
  - Mismatch: err pulse, go to IDLE (reconfiguration required).
  - ic_bus_oe not seen within VEC_TMO cycles: err pulse, go to WAIT_INT.
- ADDR_DLY: count ADDR_DLY cycles, then ACK2.
- ACK2: ic_intr_in = 0 for 1 cycle. Next cycle enter SVC with svc_valid = 1 and clr_rq = 1 << svc_id (clr_rq for that cycle only).
- SVC: hold svc_valid until svc_done = 1, then go to EOI.
  - svc_done in the same cycle SVC is entered is accepted.
  - svc_done outside SVC is ignored.
- EOI: 1 cycle with ic_bus_out = EOI word and ic_intr_in = 0. svc_valid drops on entry.
  - Polling EOI word: {5'b10100, svc_id}.
  - Priority EOI word: {5'b01100, svc_id}.
- GAP: count GAP_DLY cycles, then WAIT_INT. ic_intr_out is ignored during GAP, even if already high.
- Counters: 8-bit, count down from the parameter value to 1 inclusive. Delay is exactly the parameter value in cycles.
- Never drive ic_intr_in low while ic_bus_oe = 1, except in ACK2.

Test Plan:
- Polling: cfg_mode = 0, cfg_start. Controller model raises intr_out and returns vector 8'h59 -> ic_bus_out = 8'h01 for 1 cycle; ACK1 exactly 6 cycles after intr_out; svc_id = 1, clr_rq = 8'h02; after svc_done, EOI word 8'hA1 with ic_intr_in = 0 for 1 cycle.
- Priority config: cfg_mode = 1, cfg_prio = order 5,3,7,0,4,2,6,1 -> bus sequence 8'hAE, 8'hE2, 8'h8A, 8'hC6 on consecutive cycles; vector 8'h9D gives svc_id = 5 and EOI word 8'h65.
- Bad vector: priority mode, model returns 8'h5D -> err pulse 1 cycle, state IDLE, busy = 0, no clr_rq, no EOI.
- Timeout: bus_oe never asserts after ACK1 -> err exactly VEC_TMO cycles later, return to WAIT_INT, and the next interrupt is serviced normally.
- Reset mid-SVC: rst_in low while svc_valid = 1 -> same cycle svc_valid = 0, ic_intr_in = 1, ic_bus_out = 8'h00; cfg_start while busy is ignored.
- Back-to-back: intr_out held high through EOI -> no ack during GAP; next ACK1 at exactly GAP_DLY + ACK_DLY + 1 cycles after EOI.
